// File: rtl/dmem_arb_pkg.sv
// Shared types, constants and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W  = 64;
    localparam int unsigned DEF_DATA_W  = 64;
    localparam int unsigned DEF_MEM_LAT = 1;

    // Accesses are whole 64-bit words: the low three address bits must be zero.
    localparam int unsigned ALIGN_W = 3;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    // True when the byte address does not sit on a 64-bit word boundary.
    function automatic logic misaligned(input logic [ALIGN_W-1:0] addr_lo);
        return addr_lo != '0;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: combinational pick, remembers the last winner.
module arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_winner_c,
    output logic       o_valid_c
);

    logic r_last_winner;

    // Lone requester wins outright; on contention the port that did not win last time goes.
    always_comb begin
        o_valid_c  = |i_req;
        o_winner_c = PORT_CORE;
        if (i_req == 2'b11) begin
            o_winner_c = ~r_last_winner;
        end else if (i_req[PORT_AUX]) begin
            o_winner_c = PORT_AUX;
        end
    end

    // Reset to aux so the core wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_winner <= PORT_AUX;
        end else if (i_take && o_valid_c) begin
            r_last_winner <= o_winner_c;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single-port data memory between core and aux masters.
// A read holds its address for one cycle so it is stable at the memory, then waits
// MEM_LAT cycles for the data; this gives done at 2+MEM_LAT cycles after the sample.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned MEM_LAT = DEF_MEM_LAT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic              c_err,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;

    logic              r_owner;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_c_gnt, r_a_gnt, r_c_done, r_a_done, r_c_err, r_a_err;
    logic [DATA_W-1:0] r_c_rdata, r_a_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_wr;
    logic              r_busy;

    logic              w_owner_nxt, w_we_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_c_gnt_nxt, w_a_gnt_nxt, w_c_done_nxt, w_a_done_nxt;
    logic              w_c_err_nxt, w_a_err_nxt;
    logic [DATA_W-1:0] w_c_rdata_nxt, w_a_rdata_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_mem_wr_nxt;
    logic              w_busy_nxt;

    logic [1:0]        w_req;
    logic              w_take;
    logic              w_winner;
    logic              w_valid;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_mis;
    logic              w_last_rd;

    assign w_req  = {a_req, c_req};
    assign w_take = (r_state == ARB_IDLE);

    arb_rr2 u_rr (
        .clk        (clk),
        .rst_n      (rst),
        .i_req      (w_req),
        .i_take     (w_take),
        .o_winner_c (w_winner),
        .o_valid_c  (w_valid)
    );

    // Fields of whichever port the picker selected this cycle.
    assign w_sel_we    = (w_winner == PORT_AUX) ? a_we    : c_we;
    assign w_sel_addr  = (w_winner == PORT_AUX) ? a_addr  : c_addr;
    assign w_sel_wdata = (w_winner == PORT_AUX) ? a_wdata : c_wdata;
    assign w_sel_mis   = misaligned(w_sel_addr[ALIGN_W-1:0]);
    assign w_last_rd   = (r_cnt == CNT_W'(MEM_LAT));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = w_sel_mis ? ARB_DONE : ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (r_we || w_last_rd) begin
                    w_state_nxt = ARB_DONE;
                end
            end
            ARB_DONE: w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    // Next values of every registered output and the latched request fields.
    always_comb begin
        w_owner_nxt     = r_owner;
        w_we_nxt        = r_we;
        w_cnt_nxt       = r_cnt;
        w_c_gnt_nxt     = 1'b0;
        w_a_gnt_nxt     = 1'b0;
        w_c_done_nxt    = 1'b0;
        w_a_done_nxt    = 1'b0;
        w_c_err_nxt     = 1'b0;
        w_a_err_nxt     = 1'b0;
        w_c_rdata_nxt   = r_c_rdata;
        w_a_rdata_nxt   = r_a_rdata;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wr_nxt    = 1'b0;
        w_busy_nxt      = (w_state_nxt != ARB_IDLE);
        case (r_state)
            ARB_IDLE: begin
                if (w_valid) begin
                    w_owner_nxt = w_winner;
                    w_we_nxt    = w_sel_we;
                    w_cnt_nxt   = '0;
                    w_c_gnt_nxt = (w_winner == PORT_CORE);
                    w_a_gnt_nxt = (w_winner == PORT_AUX);
                    if (w_sel_mis) begin
                        // No memory cycle: grant and error completion land together.
                        w_c_done_nxt = (w_winner == PORT_CORE);
                        w_a_done_nxt = (w_winner == PORT_AUX);
                        w_c_err_nxt  = (w_winner == PORT_CORE);
                        w_a_err_nxt  = (w_winner == PORT_AUX);
                    end else begin
                        w_mem_addr_nxt = w_sel_addr;
                        if (w_sel_we) begin
                            w_mem_wr_nxt    = 1'b1;
                            w_mem_wdata_nxt = w_sel_wdata;
                        end
                    end
                end
            end
            ARB_ACCESS: begin
                if (r_we || w_last_rd) begin
                    w_c_done_nxt = (r_owner == PORT_CORE);
                    w_a_done_nxt = (r_owner == PORT_AUX);
                    if (!r_we) begin
                        if (r_owner == PORT_AUX) begin
                            w_a_rdata_nxt = mem_rdata;
                        end else begin
                            w_c_rdata_nxt = mem_rdata;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner     <= PORT_CORE;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_c_gnt     <= 1'b0;
            r_a_gnt     <= 1'b0;
            r_c_done    <= 1'b0;
            r_a_done    <= 1'b0;
            r_c_err     <= 1'b0;
            r_a_err     <= 1'b0;
            r_c_rdata   <= '0;
            r_a_rdata   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wr    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_owner     <= w_owner_nxt;
            r_we        <= w_we_nxt;
            r_cnt       <= w_cnt_nxt;
            r_c_gnt     <= w_c_gnt_nxt;
            r_a_gnt     <= w_a_gnt_nxt;
            r_c_done    <= w_c_done_nxt;
            r_a_done    <= w_a_done_nxt;
            r_c_err     <= w_c_err_nxt;
            r_a_err     <= w_a_err_nxt;
            r_c_rdata   <= w_c_rdata_nxt;
            r_a_rdata   <= w_a_rdata_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign c_gnt     = r_c_gnt;
    assign a_gnt     = r_a_gnt;
    assign c_done    = r_c_done;
    assign a_done    = r_a_done;
    assign c_err     = r_c_err;
    assign a_err     = r_a_err;
    assign c_rdata   = r_c_rdata;
    assign a_rdata   = r_a_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wr    = r_mem_wr;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a MEM_LAT=1 instance for the bulk of the scenarios and a
// MEM_LAT=3 instance for the long-latency read. Expectations come from a transaction
// model: round-robin order, per-kind completion latency and a shadow of memory contents.
module tb_dmem_arbiter;

    localparam int unsigned AW   = 64;
    localparam int unsigned DW   = 64;
    localparam int unsigned LAT1 = 1;
    localparam int unsigned LAT3 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance with MEM_LAT=1 ----------------
    logic          c_req, c_we, c_gnt, c_done, c_err;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          a_req, a_we, a_gnt, a_done, a_err;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_wr, busy;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1)) u_dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory with one cycle of read latency, plus a backdoor preload.
    logic [63:0] mem1 [128];
    logic [63:0] rd1;
    logic        pre1_we;
    logic [6:0]  pre1_idx;
    logic [63:0] pre1_val;
    always @(posedge clk) begin
        if (pre1_we) mem1[pre1_idx] <= pre1_val;
        else if (mem_wr) mem1[mem_addr[9:3]] <= mem_wdata;
        rd1 <= mem1[mem_addr[9:3]];
    end
    assign mem_rdata = rd1;

    // ---------------- instance with MEM_LAT=3 ----------------
    logic          t_c_req, t_c_we, t_c_gnt, t_c_done, t_c_err;
    logic [AW-1:0] t_c_addr;
    logic [DW-1:0] t_c_wdata, t_c_rdata;
    logic          t_a_req, t_a_we, t_a_gnt, t_a_done, t_a_err;
    logic [AW-1:0] t_a_addr;
    logic [DW-1:0] t_a_wdata, t_a_rdata;
    logic [AW-1:0] t_mem_addr;
    logic [DW-1:0] t_mem_wdata, t_mem_rdata;
    logic          t_mem_wr, t_busy;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3)) u_dut3 (
        .clk(clk), .rst(rst),
        .c_req(t_c_req), .c_we(t_c_we), .c_addr(t_c_addr), .c_wdata(t_c_wdata),
        .c_gnt(t_c_gnt), .c_done(t_c_done), .c_err(t_c_err), .c_rdata(t_c_rdata),
        .a_req(t_a_req), .a_we(t_a_we), .a_addr(t_a_addr), .a_wdata(t_a_wdata),
        .a_gnt(t_a_gnt), .a_done(t_a_done), .a_err(t_a_err), .a_rdata(t_a_rdata),
        .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_wr(t_mem_wr),
        .mem_rdata(t_mem_rdata), .busy(t_busy)
    );

    logic [63:0] mem3 [128];
    logic [63:0] rp3 [3];
    logic        pre3_we;
    logic [6:0]  pre3_idx;
    logic [63:0] pre3_val;
    always @(posedge clk) begin
        if (pre3_we) mem3[pre3_idx] <= pre3_val;
        else if (t_mem_wr) mem3[t_mem_addr[9:3]] <= t_mem_wdata;
        rp3[0] <= mem3[t_mem_addr[9:3]];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign t_mem_rdata = rp3[2];

    // ---------------- reference model state ----------------
    logic [63:0] shadow [128];
    logic [63:0] m_rd [2];       // expected rdata per port (0 core, 1 aux)
    logic        m_last;         // last granted port
    logic [63:0] m_mem_addr;     // last address presented to memory

    task automatic preload1(input logic [6:0] idx, input logic [63:0] val);
        @(negedge clk);
        pre1_we = 1'b1; pre1_idx = idx; pre1_val = val;
        @(negedge clk);
        pre1_we = 1'b0;
        shadow[idx] = val;
    endtask

    task automatic model_reset();
        m_last     = 1'b1;
        m_rd[0]    = '0;
        m_rd[1]    = '0;
        m_mem_addr = '0;
    endtask

    // One transaction per enabled port, issued together; checks order, timing, data.
    task automatic run_pair(input logic cv, input logic cw, input logic [63:0] ca, input logic [63:0] cd,
                            input logic av, input logic aw, input logic [63:0] aa, input logic [63:0] ad);
        logic        v [2];
        logic        w [2];
        logic [63:0] addr_v [2];
        logic [63:0] wd [2];
        logic        mis [2];
        logic        ee [2];
        logic        ae [2];
        logic        gv [2];
        logic        dv [2];
        logic        ev [2];
        logic [63:0] act_rd;
        int          eg [2], ed [2], ag [2], adn [2], ng [2], nd [2];
        int          order [2];
        int          n_ord, exp_wr, n_wr, n_cyc;
        logic        first;
        v[0] = cv; w[0] = cw; addr_v[0] = ca; wd[0] = cd;
        v[1] = av; w[1] = aw; addr_v[1] = aa; wd[1] = ad;
        for (int p = 0; p < 2; p++) begin
            mis[p] = (addr_v[p] % 8) != 0;
            eg[p] = -1; ed[p] = -1; ag[p] = -1; adn[p] = -1;
            ng[p] = 0; nd[p] = 0; ee[p] = 1'b0; ae[p] = 1'b0;
        end
        n_ord = 0;
        if (v[0] && v[1]) begin
            first = ~m_last;
            order[0] = int'(first); order[1] = int'(~first); n_ord = 2;
        end else if (v[0]) begin
            order[0] = 0; n_ord = 1;
        end else if (v[1]) begin
            order[0] = 1; n_ord = 1;
        end
        exp_wr = 0;
        for (int k = 0; k < n_ord; k++) begin
            int p;
            p = order[k];
            eg[p] = (k == 0) ? 1 : ed[order[0]] + 2;
            if (mis[p]) begin
                ed[p] = eg[p]; ee[p] = 1'b1;
            end else if (w[p]) begin
                ed[p] = eg[p] + 1;
                shadow[addr_v[p][9:3]] = wd[p];
                exp_wr++;
                m_mem_addr = addr_v[p];
            end else begin
                ed[p] = eg[p] + 1 + int'(LAT1);
                m_rd[p] = shadow[addr_v[p][9:3]];
                m_mem_addr = addr_v[p];
            end
            m_last = p[0];
        end
        n_cyc = ((ed[0] > ed[1]) ? ed[0] : ed[1]) + 3;

        @(negedge clk);
        c_req = cv; c_we = cw; c_addr = ca; c_wdata = cd;
        a_req = av; a_we = aw; a_addr = aa; a_wdata = ad;
        n_wr = 0;
        for (int cyc = 1; cyc <= n_cyc; cyc++) begin
            @(negedge clk);
            gv[0] = c_gnt;  gv[1] = a_gnt;
            dv[0] = c_done; dv[1] = a_done;
            ev[0] = c_err;  ev[1] = a_err;
            if (mem_wr) n_wr++;
            for (int p = 0; p < 2; p++) begin
                if (gv[p]) begin
                    ng[p]++;
                    if (ag[p] < 0) ag[p] = cyc;
                end
                if (dv[p]) begin
                    nd[p]++;
                    if (adn[p] < 0) begin adn[p] = cyc; ae[p] = ev[p]; end
                end
            end
            // Fields may change once granted; the arbiter must have latched them.
            if (c_gnt) begin c_req = 1'b0; c_addr = {$urandom, $urandom}; c_wdata = {$urandom, $urandom}; c_we = ~c_we; end
            if (a_gnt) begin a_req = 1'b0; a_addr = {$urandom, $urandom}; a_wdata = {$urandom, $urandom}; a_we = ~a_we; end
        end
        c_req = 1'b0; a_req = 1'b0;

        for (int p = 0; p < 2; p++) begin
            checks++;
            if (ng[p] !== (v[p] ? 1 : 0) || ag[p] !== eg[p]) begin
                errors++;
                $display("FAIL grant_p%0d: got cycle %0d count %0d, want cycle %0d count %0d",
                         p, ag[p], ng[p], eg[p], v[p] ? 1 : 0);
            end
            checks++;
            if (nd[p] !== (v[p] ? 1 : 0) || adn[p] !== ed[p]) begin
                errors++;
                $display("FAIL done_p%0d: got cycle %0d count %0d, want cycle %0d count %0d",
                         p, adn[p], nd[p], ed[p], v[p] ? 1 : 0);
            end
            if (v[p]) begin
                checks++;
                if (ae[p] !== ee[p]) begin
                    errors++;
                    $display("FAIL err_p%0d: got %0b want %0b", p, ae[p], ee[p]);
                end
            end
            act_rd = (p == 1) ? a_rdata : c_rdata;
            checks++;
            if (act_rd !== m_rd[p]) begin
                errors++;
                $display("FAIL rdata_p%0d: got %h want %h", p, act_rd, m_rd[p]);
            end
        end
        checks++;
        if (n_wr !== exp_wr) begin
            errors++;
            $display("FAIL mem_wr_cycles: got %0d want %0d", n_wr, exp_wr);
        end
        checks++;
        if (mem_addr !== m_mem_addr) begin
            errors++;
            $display("FAIL mem_addr_hold: got %h want %h", mem_addr, m_mem_addr);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle: got %0b want 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({c_gnt, a_gnt, c_done, a_done, c_err, a_err, mem_wr, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {c_gnt, a_gnt, c_done, a_done, c_err, a_err, mem_wr, busy});
        end
        checks++;
        if (c_rdata !== '0 || a_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h want 0/0", c_rdata, a_rdata);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_store_load();
        run_pair(1'b1, 1'b1, 64'h10, 64'hDEADBEEF_00000001, 1'b0, 1'b0, 64'h0, 64'h0);
        run_pair(1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        checks++;
        if (c_rdata !== 64'hDEADBEEF_00000001) begin
            errors++;
            $display("FAIL store_load_value: got %h want deadbeef00000001", c_rdata);
        end
    endtask

    task automatic test_contention();
        preload1(7'h08, 64'hC0C0_0000_0000_0040);
        preload1(7'h09, 64'hA0A0_0000_0000_0048);
        repeat (2) run_pair(1'b1, 1'b0, 64'h40, 64'h0, 1'b1, 1'b0, 64'h48, 64'h0);
        // Back-to-back writes: one memory write every three cycles.
        run_pair(1'b1, 1'b1, 64'h50, 64'h1111, 1'b1, 1'b1, 64'h58, 64'h2222);
    endtask

    task automatic test_misaligned();
        run_pair(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h13, 64'h0);
        run_pair(1'b1, 1'b1, 64'h44, 64'hBAD, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic test_isolation();
        preload1(7'h01, 64'h55);
        run_pair(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h8, 64'h0);
        run_pair(1'b1, 1'b1, 64'h8, 64'hFEED_F00D, 1'b0, 1'b0, 64'h0, 64'h0);
        checks++;
        if (a_rdata !== 64'h55) begin
            errors++;
            $display("FAIL isolation_aux: got %h want 55", a_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_bad;
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h40; a_req = 1'b0;
        @(negedge clk);
        c_req = 1'b0;
        checks++;
        if (c_gnt !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset: got gnt %0b busy %0b want 1 1", c_gnt, busy);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({c_gnt, a_gnt, c_done, a_done, c_err, a_err, mem_wr, busy} !== 8'h00 ||
            mem_addr !== '0 || c_rdata !== '0 || a_rdata !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: flags %b addr %h rdata %h/%h want all 0",
                     {c_gnt, a_gnt, c_done, a_done, c_err, a_err, mem_wr, busy}, mem_addr, c_rdata, a_rdata);
        end
        saw_bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (c_done || a_done || busy) saw_bad = 1'b1;
        end
        checks++;
        if (saw_bad !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got activity %0b want 0", saw_bad);
        end
        rst = 1'b1;
        model_reset();
        run_pair(1'b1, 1'b0, 64'h40, 64'h0, 1'b1, 1'b0, 64'h48, 64'h0);
    endtask

    task automatic test_random();
        logic        cv, av, cw, aw;
        logic [63:0] ca, aa;
        for (int i = 0; i < 8; i++) preload1(7'(8'h20 + 8'(i)), {$urandom, $urandom});
        for (int it = 0; it < 30; it++) begin
            cv = 1'($urandom_range(0, 1));
            av = 1'($urandom_range(0, 1));
            if (!cv && !av) cv = 1'b1;
            cw = 1'($urandom_range(0, 1));
            aw = 1'($urandom_range(0, 1));
            ca = 64'(32'h100 + 8 * $urandom_range(0, 7));
            aa = 64'(32'h100 + 8 * $urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) ca = ca + 64'($urandom_range(1, 7));
            if ($urandom_range(0, 5) == 0) aa = aa + 64'($urandom_range(1, 7));
            run_pair(cv, cw, ca, {$urandom, $urandom}, av, aw, aa, {$urandom, $urandom});
        end
    endtask

    task automatic test_lat3();
        logic [31:0] busy_mask, exp_mask;
        logic [63:0] got_rd;
        int          gcyc, dcyc, n_wr;
        @(negedge clk);
        pre3_we = 1'b1; pre3_idx = 7'h04; pre3_val = 64'h0123456789ABCDEF;
        @(negedge clk);
        pre3_we = 1'b0;
        t_c_req = 1'b1; t_c_we = 1'b0; t_c_addr = 64'h20;
        busy_mask = '0; gcyc = -1; dcyc = -1; n_wr = 0; got_rd = '0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (t_c_gnt && gcyc < 0) begin gcyc = cyc; t_c_req = 1'b0; t_c_addr = 64'h0; end
            if (t_busy) busy_mask[cyc] = 1'b1;
            if (t_mem_wr) n_wr++;
            if (t_c_done && dcyc < 0) begin dcyc = cyc; got_rd = t_c_rdata; end
        end
        exp_mask = '0;
        for (int i = 1; i <= 2 + int'(LAT3); i++) exp_mask[i] = 1'b1;
        checks++;
        if (gcyc !== 1 || dcyc !== 2 + int'(LAT3)) begin
            errors++;
            $display("FAIL lat3_timing: got gnt %0d done %0d want 1 %0d", gcyc, dcyc, 2 + int'(LAT3));
        end
        checks++;
        if (got_rd !== 64'h0123456789ABCDEF || t_c_rdata !== 64'h0123456789ABCDEF) begin
            errors++;
            $display("FAIL lat3_data: got %h/%h want 0123456789abcdef", got_rd, t_c_rdata);
        end
        checks++;
        if (busy_mask !== exp_mask || n_wr !== 0) begin
            errors++;
            $display("FAIL lat3_busy: got mask %h wr %0d want mask %h wr 0", busy_mask, n_wr, exp_mask);
        end
    endtask

    initial begin
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        t_c_req = 1'b0; t_c_we = 1'b0; t_c_addr = '0; t_c_wdata = '0;
        t_a_req = 1'b0; t_a_we = 1'b0; t_a_addr = '0; t_a_wdata = '0;
        pre1_we = 1'b0; pre1_idx = '0; pre1_val = '0;
        pre3_we = 1'b0; pre3_idx = '0; pre3_val = '0;
        for (int i = 0; i < 128; i++) shadow[i] = '0;
        model_reset();
        test_reset();
        test_store_load();
        test_contention();
        test_misaligned();
        test_isolation();
        test_reset_mid();
        test_random();
        test_lat3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
